// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, Fetch->Execute register,
// taken-branch redirect with flush and misaligned-target trap.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC   = 32'h0000_0004,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PCF,
    output logic [31:0] PCE,
    output logic [31:0] InstE,
    output logic        valid_e,
    output logic        misalign
);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] pce_q, pce_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;
    logic        redir;
    logic [31:0] tgt;

    assign imem_addr = pcf_q;
    assign PCF       = pcf_q;
    assign PCE       = pce_q;
    assign InstE     = inst_q;
    assign valid_e   = valid_q;
    assign misalign  = mis_q;

    // Next-state: boot hold, then redirect > stall > fetch > bubble.
    always_comb begin
        state_d = state_q;
        pcf_d   = pcf_q;
        pce_d   = pce_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        mis_d   = 1'b0;
        tgt     = br_target & 32'hFFFF_FFFE;
        redir   = br_taken & valid_q & (state_q == RUN);

        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (redir) begin
            // Bit 1 set means the target is not word aligned.
            pcf_d   = tgt[1] ? TRAP_PC : tgt;
            mis_d   = tgt[1];
            pce_d   = pcf_q;
            inst_d  = NOP_INSTR;
            valid_d = 1'b0;
        end else if (stall) begin
            pcf_d   = pcf_q;
        end else if (imem_ready) begin
            pce_d   = pcf_q;
            inst_d  = imem_rdata;
            valid_d = 1'b1;
            pcf_d   = pcf_q + 32'd4;
        end else begin
            pce_d   = pcf_q;
            inst_d  = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    // State register with asynchronous reset to the boot bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pcf_q   <= RESET_PC;
            pce_q   <= RESET_PC;
            inst_q  <= NOP_INSTR;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            pce_q   <= pce_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 3-stage RV32I pipeline. It owns the program counter and the Fetch→Execute pipeline register. It also applies the redirect produced by the execute-stage branch-condition logic (`br_taken`, target from the ALU). It flushes the wrong-path instruction and reports misaligned control-transfer targets.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_PC, 32'h0000_0004, PC loaded when a redirect target is misaligned.
- NOP_INSTR, 32'h0000_0013, instruction word placed in the F/E register on a bubble or flush (`addi x0,x0,0`).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard-unit hold; freezes PCF and the F/E register.
- br_taken  input  1  redirect request from execute-stage branch condition (B-type taken, JAL, JALR).
- br_target  input  32  redirect target from the execute-stage ALU.
- imem_addr  output  32  instruction memory address; equals PCF (combinational).
- imem_rdata  input  32  instruction word for imem_addr, valid when imem_ready=1.
- imem_ready  input  1  1 = imem_rdata valid this cycle.
- PCF  output  32  fetch-stage PC.
- PCE  output  32  PC of the instruction in execute.
- InstE  output  32  instruction in execute.
- valid_e  output  1  InstE is a real, non-flushed instruction.
- misalign  output  1  one-cycle pulse when a redirect target is misaligned.

## Operation
- FSM has two states: BOOT and RUN.
  - Reset forces BOOT.
  - BOOT lasts exactly one cycle after rst deasserts. In BOOT no capture occurs: PCF holds and the F/E register holds the bubble. The FSM then moves to RUN.
  - RUN persists until reset.
- Effective redirect: `redir = br_taken & valid_e & RUN`. br_taken is ignored when valid_e=0.
- Target handling:
  - Compute `tgt = br_target & 32'hFFFF_FFFE`; the LSB is cleared for JALR.
  - If tgt[1]=1, the next PCF is TRAP_PC and misalign pulses high for one cycle. Otherwise the next PCF is tgt.
- Per-cycle priority in RUN, highest first:
  1. redir: PCF ← target (or TRAP_PC). F/E ← bubble (InstE=NOP_INSTR, valid_e=0, PCE←PCF). This is a flush. It wins over stall and over imem_ready.
  2. stall: PCF, PCE, InstE and valid_e all hold.
  3. imem_ready=1: PCE←PCF, InstE←imem_rdata, valid_e←1, PCF←PCF+4.
  4. imem_ready=0: PCF holds. F/E ← bubble (NOP_INSTR, valid_e=0, PCE←PCF).
- PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- misalign is registered and is 0 in every cycle not immediately following a misaligned redirect.
- Reset values: PCF=RESET_PC, PCE=RESET_PC, InstE=NOP_INSTR, valid_e=0, misalign=0, FSM=BOOT.

## Timing
- imem_addr = PCF with zero latency. Memory read is combinational within the cycle.
- Straight-line fetch delivers one instruction per cycle into E, one cycle after its address appears on PCF.
- Redirect asserted in cycle N:
  - PCF=target in N+1.
  - InstE is a bubble in N+1.
  - The target instruction appears in InstE in N+2 if imem_ready=1 in N+1.
  - Taken-branch penalty is 1 bubble.
- A stall lasting k cycles holds all outputs constant for k cycles. Fetch resumes on the first non-stall cycle with the held PCF.
- Reset asserted mid-operation clears state asynchronously, regardless of a pending redirect or stall. The first capture happens in the second rising edge after deassertion (BOOT cycle).
- br_taken during BOOT or with valid_e=0 has no effect and produces no misalign.

## Test plan
- Reset/boot: RESET_PC=0, imem_ready=1, rst released → BOOT cycle with PCF=0 and valid_e=0; next edge InstE=mem[0], PCE=0, PCF=4, then 8, 12 on successive cycles.
- Taken branch: InstE valid at PCE=0x10, br_taken=1, br_target=0x40 → next cycle PCF=0x40, valid_e=0, InstE=0x13; following cycle PCE=0x40, valid_e=1.
- Stall vs redirect: stall=1 for 3 cycles at PCF=0x20 → PCF, PCE and InstE unchanged for 3 cycles. Then stall=1 with br_taken=1 and target 0x80 → PCF=0x80 and flush (redirect wins).
- Memory wait: imem_ready=0 for 2 cycles at PCF=0x30 → PCF stays 0x30 and two bubbles enter E; with ready=1, InstE=mem[0x30] and PCF=0x34.
- Misaligned target: JALR with br_target=0x103 → tgt=0x102 → PCF=TRAP_PC (0x4) and a one-cycle misalign pulse. br_target=0x101 → PCF=0x100 and misalign stays 0.
- Wrap and async reset: PCF=0xFFFF_FFFC with ready=1 → PCF=0x0. Asserting rst mid-cycle → outputs return to reset values before the next edge.
